// File: rtl/value_check_pkg.sv
// Shared types and defaults for the value check monitor.
package value_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam int MISMATCH_W  = 8;
  localparam int DEF_SETTLE  = 15;
  localparam int DEF_STABLE  = 2;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear wins over an increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/value_check_monitor.sv
// Clocked pass/fail sequencer: latch expected on start, wait a settle window,
// then require STABLE consecutive matches of obs before TIMEOUT compares elapse.
module value_check_monitor
  import value_check_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int STABLE  = DEF_STABLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      obs,
  input  logic [WIDTH-1:0]      expected,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [MISMATCH_W-1:0] mismatch_cnt,
  output logic [WIDTH-1:0]      last_obs
);

  localparam logic [7:0]  SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
  localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);
  localparam logic [4:0]  STABLE_V    = 5'(STABLE);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] exp_q;
  logic [3:0]       match_run;
  logic [4:0]       run_nxt;
  logic [7:0]       settle_cnt;
  logic [15:0]      timer;
  logic             match;
  logic             accept;
  logic             settle_inc;
  logic             timer_inc;
  logic             mm_inc;

  // Case equality so that any X/Z bit on the net under test fails the compare.
  assign match   = ((obs ^ exp_q) === '0);
  assign run_nxt = match ? ({1'b0, match_run} + 5'd1) : 5'd0;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    settle_inc = 1'b0;
    timer_inc  = 1'b0;
    mm_inc     = 1'b0;
    case (state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_inc = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        timer_inc = 1'b1;
        mm_inc    = !match;
        // A completed run on the last allowed sample still counts as a pass.
        if (run_nxt == STABLE_V)      state_nxt = ST_PASS;
        else if (timer == TIMER_LAST) state_nxt = ST_FAIL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      exp_q     <= '0;
      match_run <= '0;
      last_obs  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        exp_q     <= expected;
        match_run <= '0;
      end else if (state == ST_CHECK) begin
        match_run <= run_nxt[3:0];
        last_obs  <= obs;
      end
    end
  end

  sat_counter #(.W(MISMATCH_W)) u_mismatch (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (mm_inc),
    .cnt   (mismatch_cnt)
  );

  sat_counter #(.W(8)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (settle_inc),
    .cnt   (settle_cnt)
  );

  sat_counter #(.W(16)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (timer_inc),
    .cnt   (timer)
  );

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_PASS) || (state == ST_FAIL);
  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);

endmodule

// File: doc/value_check_monitor.md
Name: value_check_monitor

Overview:
- Downstream checking stage for forced/continuously-assigned nets under test.
- Samples an observed net, waits a settle window, then requires a run of consecutive matches against a latched expected value before declaring pass.
- Declares fail on timeout.
- Replaces ad-hoc "#delay then compare" initial blocks with a clocked, reusable pass/fail sequencer whose sticky results a bench top-level reports.

Parameters:
- WIDTH, 4, width of observed and expected values (1..32)
- SETTLE, 15, cycles to wait after start before the first compare (0..255)
- STABLE, 2, consecutive matching samples required for pass (1..15)
- TIMEOUT, 64, max compare cycles before fail (STABLE..65535)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active low
- start  input  1  pulse: latch expected, begin a check
- obs  input  WIDTH  net under test
- expected  input  WIDTH  reference value, sampled only when start is accepted
- busy  output  1  high in SETTLE or CHECK
- done  output  1  sticky: check finished (pass or fail)
- pass  output  1  sticky: run of STABLE matches seen
- fail  output  1  sticky: timeout reached without pass
- mismatch_cnt  output  8  mismatching samples in the current check, saturates at 255
- last_obs  output  WIDTH  obs value captured on the final compare cycle

Behaviour:
- Reset (rst_n low, async):
  - State is IDLE.
  - busy, done, pass, fail are 0.
  - mismatch_cnt is 0; last_obs is 0.
  - All internal counters are 0.
- States: IDLE, SETTLE, CHECK, PASS, FAIL.
- IDLE:
  - start=1 at edge k latches expected into exp_q, clears done/pass/fail/mismatch_cnt, and zeroes match_run and timer.
  - Next state at edge k: SETTLE, or CHECK if SETTLE==0.
- SETTLE:
  - Settle counter increments each cycle.
  - After exactly SETTLE cycles in SETTLE, go to CHECK.
  - First compare happens at edge k+SETTLE+1.
- CHECK: each edge samples obs and updates last_obs<=obs.
  - On match (obs==exp_q, 4-state: any X/Z bit counts as mismatch): match_run++.
  - On mismatch: match_run<=0 and mismatch_cnt++ (saturating).
  - timer++ every CHECK cycle.
  - If this sample makes match_run==STABLE, go to PASS.
  - Else if timer reaches TIMEOUT-1, go to FAIL.
  - Pass takes priority when both conditions occur on the same edge.
- PASS/FAIL:
  - Outputs are registered: done=1 and pass=1 (or fail=1) from the edge entering the state; busy=0.
  - A start accepted in PASS or FAIL behaves as in IDLE.
  - Otherwise the state holds indefinitely.
- Best-case pass latency: start at edge k, pass visible after edge k+SETTLE+STABLE.
- start while busy is ignored; exp_q, counters and state are unchanged.
- busy is 1 exactly in SETTLE and CHECK.
- pass and fail are mutually exclusive; never both 1.
- Changes on the expected input after start have no effect.
- rst_n low mid-check aborts immediately to reset values; no pass/fail is emitted.

Decomposition:
- Shared package value_check_pkg holds:
  - state enum typedef (IDLE/SETTLE/CHECK/PASS/FAIL)
  - 8-bit mismatch count width constant
  - default SETTLE/STABLE/TIMEOUT constants
- One natural sub-module: sat_counter (parameterised width, inc/clr, saturate).
  - Used for mismatch_cnt, the settle count and the timer.
- FSM and compare logic stay in value_check_monitor.

Test Plan:
- Defaults, expected=4'h1, obs held 4'h1, start at cycle 3 -> busy cycles 4..19; pass=1, done=1 after edge 20; mismatch_cnt=0; last_obs=4'h1.
- expected=4'h1, obs held 4'h5 -> fail=1 after edge 3+15+64; mismatch_cnt=64; last_obs=4'h5; pass stays 0.
- obs toggles 1,5,1,1 on the first four compare cycles -> match_run resets on the 5; pass after 4th compare; mismatch_cnt=1.
- obs=4'b000x, expected=4'h0 -> every sample counts as mismatch, ends in fail; then start again with obs=4'h0 -> done/fail clear, later pass=1.
- rst_n pulled low during SETTLE -> all outputs 0 asynchronously; no pass/fail until a new start; start with expected=4'hA while busy -> ignored, exp_q unchanged.
- SETTLE=0, STABLE=1, obs==expected -> pass after edge k+1; TIMEOUT=STABLE with a match on the final sample -> pass wins over fail.
